// File: rtl/csam_mac_accum.sv
// csam_mac_accum: signed multiply-accumulate stage behind the CSAM2C 8x4 multiplier, LEN products per sum.
// Define CSAM_MAC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module csam_mac_accum #(
   parameter int P_W   = 12,
   parameter int ACC_W = 16,
   parameter int LEN   = 4,
   parameter int CNT_W = $clog2(LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [P_W-1:0]   prod,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ovf
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

   localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1'b1);

   function automatic logic [ACC_W-1:0] sext(input logic [P_W-1:0] p);
      return ACC_W'(signed'(p));
   endfunction

   // Two's complement overflow: equal operand signs, result sign differs.
   function automatic logic add_ovf(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                                    input logic [ACC_W-1:0] r);
      return (a[ACC_W-1] == b[ACC_W-1]) && (r[ACC_W-1] != a[ACC_W-1]);
   endfunction

   state_t           state_r, state_s;
   logic [ACC_W-1:0] acc_r, acc_s;
   logic [ACC_W-1:0] sum_r, sum_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             out_valid_r, out_valid_s;
   logic             ovf_r, ovf_s;
   logic             in_beat_s;
   logic [ACC_W-1:0] prod_ext_s, add_s, acc_next_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             add_ovf_s;

   assign in_ready   = (state_r != DONE);
   assign in_beat_s  = in_valid & in_ready;
   assign prod_ext_s = sext(prod);
   assign add_s      = acc_r + prod_ext_s;
   assign add_ovf_s  = add_ovf(acc_r, prod_ext_s, add_s);
   assign cnt_inc_s  = cnt_r + ONE_C;

`ifdef CSAM_MAC_SAT_EN
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   // The sign of acc tells positive from negative overflow, since both operands share it.
   assign acc_next_s = !add_ovf_s ? add_s : (acc_r[ACC_W-1] ? ACC_MIN : ACC_MAX);
`else
   assign acc_next_s = add_s;
`endif

   // Next-state and datapath decode; clear overrides every other event.
   always_comb begin
      state_s     = state_r;
      acc_s       = acc_r;
      cnt_s       = cnt_r;
      sum_s       = sum_r;
      out_valid_s = out_valid_r;
      ovf_s       = ovf_r;
      if (clear) begin
         state_s     = IDLE;
         acc_s       = '0;
         cnt_s       = '0;
         out_valid_s = 1'b0;
         ovf_s       = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_beat_s) begin
                  acc_s = prod_ext_s;
                  cnt_s = ONE_C;
                  ovf_s = 1'b0;
                  if (LEN_C == ONE_C) begin
                     state_s     = DONE;
                     sum_s       = prod_ext_s;
                     out_valid_s = 1'b1;
                  end else begin
                     state_s = ACCUM;
                  end
               end else begin
                  state_s = IDLE;
               end
            end
            ACCUM: begin
               if (in_beat_s) begin
                  acc_s = acc_next_s;
                  cnt_s = cnt_inc_s;
                  ovf_s = ovf_r | add_ovf_s;
                  if (cnt_inc_s == LEN_C) begin
                     state_s     = DONE;
                     sum_s       = acc_next_s;
                     out_valid_s = 1'b1;
                  end else begin
                     state_s = ACCUM;
                  end
               end else begin
                  state_s = ACCUM;
               end
            end
            DONE: begin
               if (out_valid_r && out_ready) begin
                  state_s     = IDLE;
                  out_valid_s = 1'b0;
                  acc_s       = '0;
                  cnt_s       = '0;
               end else begin
                  state_s = DONE;
               end
            end
            default: begin
               state_s     = IDLE;
               acc_s       = '0;
               cnt_s       = '0;
               out_valid_s = 1'b0;
               ovf_s       = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         acc_r       <= '0;
         cnt_r       <= '0;
         sum_r       <= '0;
         out_valid_r <= 1'b0;
         ovf_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         acc_r       <= acc_s;
         cnt_r       <= cnt_s;
         sum_r       <= sum_s;
         out_valid_r <= out_valid_s;
         ovf_r       <= ovf_s;
      end
   end

   assign sum       = sum_r;
   assign out_valid = out_valid_r;
   assign ovf       = ovf_r;

endmodule
